// File: rtl/cakegame_pkg.sv
// Shared constants for the cakegame player-input path.
// Encoder state codes, button count and a popcount helper.
package cakegame_pkg;

    localparam int N_BUTTONS = 7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    function automatic logic [2:0] popcount(input logic [N_BUTTONS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cakegame_debounce.sv
// One board input: 2-FF synchronizer followed by a stable-count debouncer.
// The debounced bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module cakegame_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic deb_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == LAST) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/cakegame_button_encoder.sv
// Conditions the play and start buttons for cakegame.
// Accepts one play button at a time and pulses jogar on each start press.
module cakegame_button_encoder
    import cakegame_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] raw_buttons,
    input  logic                 raw_start,
    output logic [N_BUTTONS-1:0] botoes,
    output logic                 jogar,
    output logic                 multi_press,
    output logic [1:0]           enc_state
);

    logic [N_BUTTONS-1:0] deb_buttons;
    logic                 deb_start;
    logic [2:0]           pcnt;

    logic [1:0]           state_q, state_d;
    logic [N_BUTTONS-1:0] sel_q, sel_d;
    logic [N_BUTTONS-1:0] botoes_q, botoes_d;
    logic                 start_q;
    logic                 jogar_q;
    logic                 multi_q;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        cakegame_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i (clock),
            .rst_ni(reset),
            .raw_i (raw_buttons[i]),
            .deb_o (deb_buttons[i])
        );
    end

    cakegame_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
        .clk_i (clock),
        .rst_ni(reset),
        .raw_i (raw_start),
        .deb_o (deb_start)
    );

    assign pcnt = popcount(deb_buttons);

    // A swap to another button while releasing goes through IDLE first
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        botoes_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pcnt == 3'd1) begin
                    state_d  = ST_PRESSED;
                    sel_d    = deb_buttons;
                    botoes_d = deb_buttons;
                end else if (pcnt >= 3'd2) begin
                    state_d = ST_BLOCKED;
                end
            end
            ST_PRESSED: begin
                if (pcnt >= 3'd2) begin
                    state_d = ST_BLOCKED;
                end else if (pcnt == 3'd1 && |(sel_q & deb_buttons)) begin
                    botoes_d = sel_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLOCKED: begin
                if (pcnt == 3'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            botoes_q <= '0;
            start_q  <= 1'b0;
            jogar_q  <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            botoes_q <= botoes_d;
            start_q  <= deb_start;
            jogar_q  <= deb_start & ~start_q;
            multi_q  <= (state_d == ST_BLOCKED);
        end
    end

    assign botoes      = botoes_q;
    assign jogar       = jogar_q;
    assign multi_press = multi_q;
    assign enc_state   = state_q;

endmodule

// File: tb/tb_cakegame_button_encoder.sv
// Directed bench for cakegame_button_encoder with DEBOUNCE_CYCLES=4.
// Table rows plus hand-written timing sequences.
module tb_cakegame_button_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] raw_buttons = '0;
    logic       raw_start = 1'b0;
    logic [6:0] botoes;
    logic       jogar;
    logic       multi_press;
    logic [1:0] enc_state;

    int n_pass = 0;
    int n_chk  = 0;

    cakegame_button_encoder #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .raw_buttons(raw_buttons),
        .raw_start  (raw_start),
        .botoes     (botoes),
        .jogar      (jogar),
        .multi_press(multi_press),
        .enc_state  (enc_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] btn;
        logic       st;
        int         n;
        logic [6:0] e_bot;
        logic       e_jog;
        logic       e_mul;
        logic [1:0] e_st;
    } vec_t;

    vec_t tbl [14];

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_all(input string name, input logic [6:0] b, input logic j,
                           input logic m, input logic [1:0] s);
        chk({name, ".botoes"}, {1'b0, botoes}, {1'b0, b});
        chk({name, ".jogar"}, {7'd0, jogar}, {7'd0, j});
        chk({name, ".multi"}, {7'd0, multi_press}, {7'd0, m});
        chk({name, ".state"}, {6'd0, enc_state}, {6'd0, s});
    endtask

    initial begin
        bit quiet;
        tbl[0]  = '{7'h02, 1'b0, 10, 7'h02, 1'b0, 1'b0, 2'd1};
        tbl[1]  = '{7'h22, 1'b0,  6, 7'h02, 1'b0, 1'b0, 2'd1};
        tbl[2]  = '{7'h22, 1'b0,  1, 7'h00, 1'b0, 1'b1, 2'd2};
        tbl[3]  = '{7'h20, 1'b0, 10, 7'h00, 1'b0, 1'b1, 2'd2};
        tbl[4]  = '{7'h00, 1'b0,  7, 7'h00, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{7'h01, 1'b0, 10, 7'h01, 1'b0, 1'b0, 2'd1};
        tbl[6]  = '{7'h10, 1'b0,  7, 7'h00, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{7'h10, 1'b0,  1, 7'h10, 1'b0, 1'b0, 2'd1};
        tbl[8]  = '{7'h00, 1'b0, 10, 7'h00, 1'b0, 1'b0, 2'd0};
        tbl[9]  = '{7'h03, 1'b0,  7, 7'h00, 1'b0, 1'b1, 2'd2};
        tbl[10] = '{7'h00, 1'b0, 10, 7'h00, 1'b0, 1'b0, 2'd0};
        tbl[11] = '{7'h40, 1'b1,  7, 7'h40, 1'b1, 1'b0, 2'd1};
        tbl[12] = '{7'h40, 1'b1,  1, 7'h40, 1'b0, 1'b0, 2'd1};
        tbl[13] = '{7'h00, 1'b0, 10, 7'h00, 1'b0, 1'b0, 2'd0};

        // reset state
        tick(3);
        chk_all("reset", 7'h00, 1'b0, 1'b0, 2'd0);
        reset = 1'b1;
        tick(2);

        // clean press, exact latency
        raw_buttons = 7'b0000100;
        tick(6);
        chk("clean.c6", {1'b0, botoes}, 8'h00);
        tick(1);
        chk_all("clean.c7", 7'b0000100, 1'b0, 1'b0, 2'd1);
        tick(13);
        raw_buttons = '0;
        tick(6);
        chk("clean.rel6", {1'b0, botoes}, 8'h04);
        tick(1);
        chk_all("clean.rel7", 7'h00, 1'b0, 1'b0, 2'd0);
        tick(5);

        // bounce on bit0
        quiet = 1'b1;
        raw_buttons = 7'h01; tick(1); if (botoes !== 7'h00) quiet = 1'b0;
        raw_buttons = 7'h00; tick(1); if (botoes !== 7'h00) quiet = 1'b0;
        raw_buttons = 7'h01; tick(1); if (botoes !== 7'h00) quiet = 1'b0;
        raw_buttons = 7'h00; tick(1); if (botoes !== 7'h00) quiet = 1'b0;
        raw_buttons = 7'h01;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (botoes !== 7'h00) quiet = 1'b0;
        end
        chk("bounce.quiet", {7'd0, quiet}, 8'd1);
        tick(1);
        chk("bounce.c7", {1'b0, botoes}, 8'h01);
        raw_buttons = '0;
        tick(10);
        chk("bounce.rel", {1'b0, botoes}, 8'h00);

        // start pulse
        raw_start = 1'b1;
        tick(6);
        chk("start.c6", {7'd0, jogar}, 8'd0);
        tick(1);
        chk("start.c7", {7'd0, jogar}, 8'd1);
        tick(1);
        chk("start.c8", {7'd0, jogar}, 8'd0);
        tick(7);
        raw_start = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (jogar !== 1'b0) quiet = 1'b0;
        end
        chk("start.norel", {7'd0, quiet}, 8'd1);
        raw_start = 1'b1;
        tick(7);
        chk("start2.c7", {7'd0, jogar}, 8'd1);
        tick(1);
        chk("start2.c8", {7'd0, jogar}, 8'd0);
        raw_start = 1'b0;
        tick(10);

        // table rows
        for (int r = 0; r < 14; r++) begin
            raw_buttons = tbl[r].btn;
            raw_start   = tbl[r].st;
            tick(tbl[r].n);
            chk_all($sformatf("row%0d", r), tbl[r].e_bot, tbl[r].e_jog,
                    tbl[r].e_mul, tbl[r].e_st);
        end

        // reset while bit3 held
        raw_buttons = 7'b0001000;
        tick(7);
        chk("rst.pre", {1'b0, botoes}, 8'h08);
        reset = 1'b0;
        tick(1);
        chk_all("rst.r1", 7'h00, 1'b0, 1'b0, 2'd0);
        tick(1);
        chk_all("rst.r2", 7'h00, 1'b0, 1'b0, 2'd0);
        reset = 1'b1;
        tick(6);
        chk("rst.c6", {1'b0, botoes}, 8'h00);
        tick(1);
        chk("rst.c7", {1'b0, botoes}, 8'h08);
        raw_buttons = '0;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
